// File: rtl/sbox_share_stream_unloader.sv
// Consumer-side issue/collect controller for the masked S-box pipeline.
// Credit-based issue into a fixed-latency pipeline; results land in a share-preserving FIFO.
module sbox_share_stream_unloader #(
  parameter int unsigned SHARES = 3,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LAT    = 3,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SHARES*WIDTH-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [SHARES*WIDTH-1:0]   sbox_in,
  output logic                      sbox_in_valid,
  input  logic [SHARES*WIDTH-1:0]   sbox_out,
  output logic [SHARES*WIDTH-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned DataW   = SHARES * WIDTH;
  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned FlightW = $clog2(LAT + 2);
  localparam int unsigned SumW    = ((CntW > FlightW) ? CntW : FlightW) + 1;

  logic [LAT-1:0]     trk_q, trk_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [FlightW-1:0] inflight_q, inflight_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DataW-1:0]   mem_q [DEPTH];

  logic            accept;
  logic            tap;
  logic            wr_en;
  logic            pop;
  logic [SumW-1:0] credit_used;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Credit counts both buffered and in-flight tokens, so every launched token owns a slot.
  assign credit_used = SumW'(count_q) + SumW'(inflight_q);
  assign in_ready    = credit_used < SumW'(DEPTH);
  assign accept      = in_valid && in_ready;

  assign tap       = trk_q[LAT-1];
  assign wr_en     = tap;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    trk_d    = '0;
    trk_d[0] = sbox_in_valid;
    for (int unsigned i = 1; i < LAT; i++) begin
      trk_d[i] = trk_q[i-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !wr_en) begin
      inflight_d = inflight_q + FlightW'(1);
    end else if (!accept && wr_en) begin
      inflight_d = inflight_q - FlightW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // Idle cycles drive zero shares so stale mask material never enters the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      sbox_in       <= '0;
      sbox_in_valid <= 1'b0;
    end else begin
      sbox_in       <= accept ? in_data : '0;
      sbox_in_valid <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_q      <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      trk_q      <= trk_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Popped entries are wiped so no residual shares stay in storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) mem_q[wr_ptr_q] <= sbox_out;
      if (pop)   mem_q[rd_ptr_q] <= '0;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(tap && (count_q == CntW'(DEPTH))))
    else $error("pipeline result arrived while result FIFO full");

endmodule

// File: tb/tb_sbox_share_stream_unloader.sv
// Bench for sbox_share_stream_unloader: DEPTH=8 and DEPTH=4 instances share one stimulus,
// each checked every cycle against an accept-log model with a LAT-deep stub S-box.
module tb_sbox_share_stream_unloader;
  localparam int SH   = 3;
  localparam int W    = 8;
  localparam int LAT  = 3;
  localparam int N    = SH * W;
  localparam int LOGN = 16384;
  localparam logic [N-1:0] K = 24'h010101;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] in_data = '0;

  logic         rdy   [2];
  logic         sbv   [2];
  logic [N-1:0] sbin  [2];
  logic [N-1:0] sbout [2];
  logic         ov    [2];
  logic [N-1:0] od    [2];
  logic [N-1:0] pipe  [2][LAT];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int dpop [2];

  // Model: ordered log of accepted tokens; [hd,md) is buffered, [md,tl) still in the pipeline.
  logic [N-1:0] log_d [2][LOGN];
  int           log_v [2][LOGN];
  int           hd [2];
  int           md [2];
  int           tl [2];
  logic [N-1:0] m_sbin [2];
  logic         m_sbv  [2];
  logic         er, ev;
  logic [N-1:0] ed;

  always #5 clk = ~clk;

  sbox_share_stream_unloader #(.SHARES(SH), .WIDTH(W), .LAT(LAT), .DEPTH(8)) u_d8 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .sbox_in(sbin[0]), .sbox_in_valid(sbv[0]), .sbox_out(sbout[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready)
  );

  sbox_share_stream_unloader #(.SHARES(SH), .WIDTH(W), .LAT(LAT), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .sbox_in(sbin[1]), .sbox_in_valid(sbv[1]), .sbox_out(sbout[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready)
  );

  // Stub S-box: pure LAT-cycle delay of the operand with a per-share constant flip.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] <= sbin[k] ^ K;
      for (int s = 1; s < LAT; s++) pipe[k][s] <= pipe[k][s-1];
    end
  end
  assign sbout[0] = pipe[0][LAT-1];
  assign sbout[1] = pipe[1][LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      hd[k] = 0; md[k] = 0; tl[k] = 0; dpop[k] = 0;
      m_sbin[k] = '0; m_sbv[k] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int k = 0; k < 2; k++) begin
        while (md[k] < tl[k] && log_v[k][md[k]] <= cyc) md[k]++;
        ev = (md[k] > hd[k]);
        ed = ev ? log_d[k][hd[k]] : '0;
        er = (tl[k] - hd[k]) < ((k == 0) ? 8 : 4);
        chk("in_ready", k, rdy[k], er);
        chk("out_valid", k, ov[k], ev);
        chk("out_data", k, od[k], ed);
        chk("sbox_in", k, sbin[k], m_sbin[k]);
        chk("sbox_in_valid", k, sbv[k], m_sbv[k]);
        if (ov[k] && out_ready) dpop[k]++;
        if (rst) begin
          hd[k] = tl[k]; md[k] = tl[k];
          m_sbv[k] = 1'b0; m_sbin[k] = '0;
        end else begin
          m_sbv[k]  = in_valid && er;
          m_sbin[k] = m_sbv[k] ? in_data : '0;
          if (m_sbv[k] && tl[k] < LOGN) begin
            log_d[k][tl[k]] = in_data ^ K;
            log_v[k][tl[k]] = cyc + 2 + LAT;
            tl[k]++;
          end
          if (ev && out_ready) hd[k]++;
        end
      end
    end
  end

  int acc, acc1, stall, n, p0, p1;

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 0, ov[0], 1'b0);
    chk("rst_out_data", 0, od[0], '0);
    chk("rst_in_ready", 0, rdy[0], 1'b1);
    chk("rst_sbox_in_valid", 0, sbv[0], 1'b0);

    // Single token accepted at cycle 10
    while (cyc < 10) step();
    in_data = 24'h0A55C3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data = '0;
    chk("single_sbox_in", 0, sbin[0], 24'h0A55C3);
    chk("single_sbox_in_valid", 0, sbv[0], 1'b1);
    while (cyc < 14) step();
    chk("single_early_valid", 0, ov[0], 1'b0);
    step();
    chk("single_out_valid", 0, ov[0], 1'b1);
    chk("single_out_data", 0, od[0], 24'h0B54C2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_popped_valid", 0, ov[0], 1'b0);
    chk("single_popped_data", 0, od[0], '0);

    // Streaming with out_ready held high
    out_ready = 1'b1;
    p0 = dpop[0];
    for (int i = 0; i < 64; i++) begin
      in_data = {8'(i), ~8'(i), 8'(i) ^ 8'h5A};
      in_valid = 1'b1;
      chk("stream_in_ready", 0, rdy[0], 1'b1);
      step();
    end
    in_valid = 1'b0;
    repeat (12) step();
    chk("stream_pops", 0, N'(dpop[0] - p0), N'(64));

    // Backpressure
    out_ready = 1'b0;
    acc = 0;
    repeat (14) begin
      in_valid = 1'b1;
      in_data = N'($urandom);
      acc += int'(rdy[0]);
      step();
    end
    chk("bp_accepts", 0, N'(acc), N'(8));
    chk("bp_in_ready_low", 0, rdy[0], 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_in_ready_back", 0, rdy[0], 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (16) step();

    // Random stalls
    repeat (10000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      in_data = N'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();

    // Reset with 2 tokens buffered and 3 in the pipeline
    out_ready = 1'b0;
    repeat (5) begin
      in_valid = 1'b1;
      in_data = N'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("midrst_buffered", 0, ov[0], 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 0, ov[0], 1'b0);
    chk("midrst_out_data", 0, od[0], '0);
    chk("midrst_in_ready", 0, rdy[0], 1'b1);
    chk("midrst_sbox_in_valid", 0, sbv[0], 1'b0);
    p0 = dpop[0];
    out_ready = 1'b1;
    repeat (12) step();
    chk("midrst_no_output", 0, N'(dpop[0] - p0), '0);

    // DEPTH=4 under continuous traffic
    acc1 = 0;
    stall = 0;
    n = 0;
    p1 = dpop[1];
    while (acc1 < 24 && n < 200) begin
      in_valid = 1'b1;
      in_data = N'($urandom);
      acc1 += int'(rdy[1]);
      stall += int'(!rdy[1]);
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("d4_accepts_reached", 1, N'(acc1 >= 24), 1'b1);
    chk("d4_stalled", 1, N'(stall > 0), 1'b1);
    repeat (15) step();
    chk("d4_pops", 1, N'(dpop[1] - p1), N'(acc1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
